// File: rtl/x2050pkg.sv
// Shared constants for the 2050 interrupt scheduler: class codes, permanent
// storage locations of the old/new PSW pairs, and the swap FSM state type.
package x2050pkg;

   localparam logic [2:0] CLS_NONE = 3'd0;
   localparam logic [2:0] CLS_MCK  = 3'd1;
   localparam logic [2:0] CLS_PGM  = 3'd2;
   localparam logic [2:0] CLS_SVC  = 3'd3;
   localparam logic [2:0] CLS_EXT  = 3'd4;
   localparam logic [2:0] CLS_IO   = 3'd5;

   localparam logic [23:0] OLD_EXT = 24'd24;
   localparam logic [23:0] OLD_SVC = 24'd32;
   localparam logic [23:0] OLD_PGM = 24'd40;
   localparam logic [23:0] OLD_MCK = 24'd48;
   localparam logic [23:0] OLD_IO  = 24'd56;
   localparam logic [23:0] NEW_EXT = 24'd88;
   localparam logic [23:0] NEW_SVC = 24'd96;
   localparam logic [23:0] NEW_PGM = 24'd104;
   localparam logic [23:0] NEW_MCK = 24'd112;
   localparam logic [23:0] NEW_IO  = 24'd120;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ST0  = 3'd1,
      S_ST1  = 3'd2,
      S_LD0  = 3'd3,
      S_LD1  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   function automatic logic [23:0] old_addr(input logic [2:0] cls);
      case (cls)
         CLS_MCK: old_addr = OLD_MCK;
         CLS_PGM: old_addr = OLD_PGM;
         CLS_SVC: old_addr = OLD_SVC;
         CLS_EXT: old_addr = OLD_EXT;
         CLS_IO:  old_addr = OLD_IO;
         default: old_addr = 24'd0;
      endcase
   endfunction

   function automatic logic [23:0] new_addr(input logic [2:0] cls);
      case (cls)
         CLS_MCK: new_addr = NEW_MCK;
         CLS_PGM: new_addr = NEW_PGM;
         CLS_SVC: new_addr = NEW_SVC;
         CLS_EXT: new_addr = NEW_EXT;
         CLS_IO:  new_addr = NEW_IO;
         default: new_addr = 24'd0;
      endcase
   endfunction

endpackage

// File: rtl/x2050intsched_pri.sv
// x2050intpri: combinational PSW-mask gating and fixed priority encoding
// (mck > pgm > svc > ext > io) of the pending interruption classes.
module x2050intpri
   import x2050pkg::*;
(
   input  logic       i_mck_pend,
   input  logic       i_pgm_pend,
   input  logic       i_svc_pend,
   input  logic       i_ext_req,
   input  logic       i_io_req,
   input  logic [7:0] i_psw_sys,
   input  logic       i_psw_mck,
   input  logic [2:0] i_io_chan,
   output logic [2:0] o_class,
   output logic       o_valid
);

   logic w_io_en;

   // i_psw_sys[7] is PSW bit 0; channels 6 and 7 share the bit-6 mask.
   always_comb begin
      w_io_en = (i_io_chan > 3'd5) ? i_psw_sys[1] : i_psw_sys[3'd7 - i_io_chan];
      o_class = CLS_NONE;
      o_valid = 1'b0;
      if (i_mck_pend && i_psw_mck) begin
         o_class = CLS_MCK;
         o_valid = 1'b1;
      end else if (i_pgm_pend) begin
         o_class = CLS_PGM;
         o_valid = 1'b1;
      end else if (i_svc_pend) begin
         o_class = CLS_SVC;
         o_valid = 1'b1;
      end else if (i_ext_req && i_psw_sys[0]) begin
         o_class = CLS_EXT;
         o_valid = 1'b1;
      end else if (i_io_req && w_io_en) begin
         o_class = CLS_IO;
         o_valid = 1'b1;
      end
   end

endmodule

// File: rtl/x2050intsched.sv
// x2050intsched: latches interruption requests, grants at instruction boundaries
// and sequences the old-PSW store / new-PSW fetch. Option: X2050_INTSCHED_CHAIN_EN.
module x2050intsched
   import x2050pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_ibound,
   input  logic [63:0] i_psw_cur,
   input  logic [1:0]  i_ilc,
   input  logic        i_mck_req,
   input  logic        i_pgm_req,
   input  logic [7:0]  i_pgm_code,
   input  logic        i_svc_req,
   input  logic [7:0]  i_svc_code,
   input  logic        i_ext_req,
   input  logic [7:0]  i_ext_code,
   input  logic        i_io_req,
   input  logic [2:0]  i_io_chan,
   input  logic [15:0] i_io_addr,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [23:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic        o_ext_ack,
   output logic        o_io_ack,
   output logic        o_psw_load,
   output logic [63:0] o_psw_new,
   output logic        o_busy,
   output logic [2:0]  o_int_class
);

   state_t      r_state;
   state_t      w_next;
   logic        r_mck_pend, r_pgm_pend, r_svc_pend;
   logic [7:0]  r_pgm_code, r_svc_code;
   logic [2:0]  r_class;
   logic [63:0] r_old_psw;
   logic [63:0] r_psw_new;
   logic        r_ext_ack, r_io_ack, r_psw_load;
   logic        w_eval, w_grant, w_pri_valid;
   logic [2:0]  w_pri_class;
   logic [63:0] w_eval_psw, w_old_psw;
   logic [15:0] w_code;
   logic [1:0]  w_ilc;
   logic        w_unused_psw;

`ifdef X2050_INTSCHED_CHAIN_EN
   assign w_eval     = ((r_state == S_IDLE) && i_ibound) || (r_state == S_DONE);
   assign w_eval_psw = (r_state == S_DONE) ? r_psw_new : i_psw_cur;
`else
   assign w_eval     = (r_state == S_IDLE) && i_ibound;
   assign w_eval_psw = i_psw_cur;
`endif
   assign w_grant      = w_eval && w_pri_valid;
   assign w_unused_psw = ^i_psw_cur[47:30];

   // svc waits behind a pending pgm purely through priority order.
   x2050intpri u_pri (
      .i_mck_pend (r_mck_pend),
      .i_pgm_pend (r_pgm_pend),
      .i_svc_pend (r_svc_pend),
      .i_ext_req  (i_ext_req),
      .i_io_req   (i_io_req),
      .i_psw_sys  (w_eval_psw[63:56]),
      .i_psw_mck  (w_eval_psw[50]),
      .i_io_chan  (i_io_chan),
      .o_class    (w_pri_class),
      .o_valid    (w_pri_valid)
   );

   // Old PSW: code in bits 16:31, ILC in bits 32:33 (PSW bit 0 = [63]).
   always_comb begin
      w_code = 16'h0000;
      w_ilc  = 2'b00;
      case (w_pri_class)
         CLS_PGM: begin
            w_code = {8'h00, r_pgm_code};
            w_ilc  = i_ilc;
         end
         CLS_SVC: begin
            w_code = {8'h00, r_svc_code};
            w_ilc  = i_ilc;
         end
         CLS_EXT: w_code = {8'h00, i_ext_code};
         CLS_IO:  w_code = i_io_addr;
         default: w_code = 16'h0000;
      endcase
`ifdef X2050_INTSCHED_CHAIN_EN
      if (r_state == S_DONE) w_ilc = r_psw_new[31:30];
`endif
      w_old_psw = {w_eval_psw[63:48], w_code, w_ilc, w_eval_psw[29:0]};
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Storage port is decoded from the state register, so it drops with reset.
   always_comb begin
      w_next      = r_state;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = 24'd0;
      o_mem_wdata = 32'd0;
      case (r_state)
         S_IDLE: if (w_grant) w_next = S_ST0;
         S_ST0: begin
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = old_addr(r_class);
            o_mem_wdata = r_old_psw[63:32];
            if (i_mem_ack) w_next = S_ST1;
         end
         S_ST1: begin
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = old_addr(r_class) + 24'd4;
            o_mem_wdata = r_old_psw[31:0];
            if (i_mem_ack) w_next = S_LD0;
         end
         S_LD0: begin
            o_mem_req  = 1'b1;
            o_mem_addr = new_addr(r_class);
            if (i_mem_ack) w_next = S_LD1;
         end
         S_LD1: begin
            o_mem_req  = 1'b1;
            o_mem_addr = new_addr(r_class) + 24'd4;
            if (i_mem_ack) w_next = S_DONE;
         end
         S_DONE:  w_next = w_grant ? S_ST0 : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mck_pend <= 1'b0;
         r_pgm_pend <= 1'b0;
         r_svc_pend <= 1'b0;
         r_pgm_code <= 8'h00;
         r_svc_code <= 8'h00;
         r_class    <= CLS_NONE;
         r_old_psw  <= 64'd0;
         r_psw_new  <= 64'd0;
         r_ext_ack  <= 1'b0;
         r_io_ack   <= 1'b0;
         r_psw_load <= 1'b0;
      end else begin
         r_ext_ack  <= w_grant && (w_pri_class == CLS_EXT);
         r_io_ack   <= w_grant && (w_pri_class == CLS_IO);
         r_psw_load <= (r_state == S_DONE);
         if (w_grant) begin
            r_class   <= w_pri_class;
            r_old_psw <= w_old_psw;
         end
         // A new pulse wins over the clear of the grant it coincides with.
         if (i_mck_req)                               r_mck_pend <= 1'b1;
         else if (w_grant && (w_pri_class == CLS_MCK)) r_mck_pend <= 1'b0;
         if (i_pgm_req) begin
            r_pgm_pend <= 1'b1;
            r_pgm_code <= i_pgm_code;
         end else if (w_grant && (w_pri_class == CLS_PGM)) begin
            r_pgm_pend <= 1'b0;
         end
         if (i_svc_req) begin
            r_svc_pend <= 1'b1;
            r_svc_code <= i_svc_code;
         end else if (w_grant && (w_pri_class == CLS_SVC)) begin
            r_svc_pend <= 1'b0;
         end
         if ((r_state == S_LD0) && i_mem_ack) r_psw_new[63:32] <= i_mem_rdata;
         if ((r_state == S_LD1) && i_mem_ack) r_psw_new[31:0]  <= i_mem_rdata;
      end
   end

   assign o_ext_ack   = r_ext_ack;
   assign o_io_ack    = r_io_ack;
   assign o_psw_load  = r_psw_load;
   assign o_psw_new   = r_psw_new;
   assign o_busy      = (r_state != S_IDLE);
   assign o_int_class = (r_state != S_IDLE) ? r_class : CLS_NONE;

endmodule

// File: tb/tb_x2050intsched.sv
// Directed bench for x2050intsched: vector table of single swaps plus
// hand-written priority, retention, reset and chaining sequences.
`timescale 1ns/1ps
module tb_x2050intsched;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_ibound = 1'b0;
   logic [63:0] i_psw_cur = 64'd0;
   logic [1:0]  i_ilc = 2'd0;
   logic        i_mck_req = 1'b0;
   logic        i_pgm_req = 1'b0;
   logic [7:0]  i_pgm_code = 8'h00;
   logic        i_svc_req = 1'b0;
   logic [7:0]  i_svc_code = 8'h00;
   logic        i_ext_req = 1'b0;
   logic [7:0]  i_ext_code = 8'h00;
   logic        i_io_req = 1'b0;
   logic [2:0]  i_io_chan = 3'd0;
   logic [15:0] i_io_addr = 16'h0000;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_rdata = 32'd0;
   logic        o_mem_req, o_mem_we, o_ext_ack, o_io_ack, o_psw_load, o_busy;
   logic [23:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [63:0] o_psw_new;
   logic [2:0]  o_int_class;

   always #5 i_clk = ~i_clk;

   x2050intsched dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ibound(i_ibound),
      .i_psw_cur(i_psw_cur), .i_ilc(i_ilc),
      .i_mck_req(i_mck_req), .i_pgm_req(i_pgm_req), .i_pgm_code(i_pgm_code),
      .i_svc_req(i_svc_req), .i_svc_code(i_svc_code),
      .i_ext_req(i_ext_req), .i_ext_code(i_ext_code),
      .i_io_req(i_io_req), .i_io_chan(i_io_chan), .i_io_addr(i_io_addr),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
      .o_ext_ack(o_ext_ack), .o_io_ack(o_io_ack), .o_psw_load(o_psw_load),
      .o_psw_new(o_psw_new), .o_busy(o_busy), .o_int_class(o_int_class)
   );

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;
   int ext_acks = 0;
   int io_acks = 0;
   int loads = 0;
   logic [31:0] mem_words [0:31];
   logic [23:0] log_addr [$];
   logic        log_we [$];
   logic [31:0] log_data [$];

   typedef struct {
      int          cls;
      logic [7:0]  code;
      logic [1:0]  ilc;
      logic [63:0] psw;
      logic [2:0]  chan;
      logic [15:0] ioaddr;
      int          delay;
      logic [23:0] old_a;
      logic [23:0] new_a;
      logic [31:0] w0;
      logic [31:0] w1;
      int          lat;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Storage model: acks after ack_delay stall cycles, logs each completed beat.
   initial begin : mem_resp
      int          wc;
      logic        mid;
      logic        h_we;
      logic [23:0] h_addr;
      logic [31:0] h_data;
      wc = 0;
      mid = 1'b0;
      h_we = 1'b0;
      h_addr = 24'd0;
      h_data = 32'd0;
      forever begin
         @(negedge i_clk);
         i_mem_ack = 1'b0;
         if (o_mem_req && i_reset_n) begin
            if (mid) begin
               chk("mem_stable", {7'd0, o_mem_we, o_mem_addr, o_mem_wdata}, {7'd0, h_we, h_addr, h_data});
            end else begin
               h_we = o_mem_we;
               h_addr = o_mem_addr;
               h_data = o_mem_wdata;
               mid = 1'b1;
               wc = 0;
            end
            if (wc == ack_delay) begin
               i_mem_ack = 1'b1;
               i_mem_rdata = o_mem_we ? 32'd0 : mem_words[o_mem_addr[6:2]];
               log_addr.push_back(o_mem_addr);
               log_we.push_back(o_mem_we);
               log_data.push_back(o_mem_we ? o_mem_wdata : i_mem_rdata);
               mid = 1'b0;
            end else begin
               wc++;
            end
         end else begin
            mid = 1'b0;
         end
      end
   end

   // Level sources drop their request on the ack; count pulses.
   initial begin : src_mon
      forever begin
         @(negedge i_clk);
         if (o_ext_ack) begin
            ext_acks++;
            i_ext_req = 1'b0;
         end
         if (o_io_ack) begin
            io_acks++;
            i_io_req = 1'b0;
         end
         if (o_psw_load) loads++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_data.delete();
   endtask

   task automatic pulse_req(input int cls, input logic [7:0] code);
      if (cls == 1) i_mck_req = 1'b1;
      if (cls == 2) begin i_pgm_req = 1'b1; i_pgm_code = code; end
      if (cls == 3) begin i_svc_req = 1'b1; i_svc_code = code; end
      @(negedge i_clk);
      i_mck_req = 1'b0;
      i_pgm_req = 1'b0;
      i_svc_req = 1'b0;
   endtask

   task automatic take(input logic [63:0] psw, input logic [1:0] ilc);
      i_psw_cur = psw;
      i_ilc = ilc;
      i_ibound = 1'b1;
      @(negedge i_clk);
      i_ibound = 1'b0;
   endtask

   // Called on the negedge one cycle after the boundary (lat = 1 there).
   task automatic wait_load(output int lat);
      lat = 1;
      while (!o_psw_load && lat < 200) begin
         @(negedge i_clk);
         lat++;
      end
      if (!o_psw_load) begin
         checks++;
         errors++;
         $display("FAIL load_timeout actual=%0d cycles required=o_psw_load", lat);
      end
   endtask

   initial begin : main
      int          lat;
      int          acks0;
      int          loads0;
      logic [23:0] exp_a [4];
      logic [23:0] seq_a [12];
      logic [31:0] tmp;
      for (int k = 0; k < 32; k++) mem_words[k] = 32'hC0DE_0000 | (k * 4);

      vecs[0] = '{2, 8'h06, 2'd2, 64'hFF00_FFFF_0000_1234, 3'd0, 16'h0000, 0,
                  24'd40, 24'd104, 32'hFF00_0006, 32'h8000_1234, 6};
      vecs[1] = '{3, 8'h2A, 2'd1, 64'h0000_0000_FFFF_FFFF, 3'd0, 16'h0000, 0,
                  24'd32, 24'd96, 32'h0000_002A, 32'h7FFF_FFFF, 6};
      vecs[2] = '{1, 8'h00, 2'd3, 64'h0004_1111_C000_0000, 3'd0, 16'h0000, 3,
                  24'd48, 24'd112, 32'h0004_0000, 32'h0000_0000, 18};
      vecs[3] = '{4, 8'h40, 2'd2, 64'h0100_ABCD_4000_0055, 3'd0, 16'h0000, 0,
                  24'd24, 24'd88, 32'h0100_0040, 32'h0000_0055, 6};
      vecs[4] = '{5, 8'h00, 2'd1, 64'h1000_0000_0000_0000, 3'd3, 16'h0123, 1,
                  24'd56, 24'd120, 32'h1000_0123, 32'h0000_0000, 10};
      vecs[5] = '{5, 8'h00, 2'd0, 64'h0200_5555_FFFF_0000, 3'd7, 16'hBEEF, 0,
                  24'd56, 24'd120, 32'h0200_BEEF, 32'h3FFF_0000, 6};

      // Reset values
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
      chk("rst_mem_we", {63'd0, o_mem_we}, 64'd0);
      chk("rst_mem_addr", {40'd0, o_mem_addr}, 64'd0);
      chk("rst_mem_wdata", {32'd0, o_mem_wdata}, 64'd0);
      chk("rst_psw_new", o_psw_new, 64'd0);
      chk("rst_acks", {62'd0, o_ext_ack, o_io_ack}, 64'd0);
      chk("rst_psw_load", {63'd0, o_psw_load}, 64'd0);
      chk("rst_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_class", {61'd0, o_int_class}, 64'd0);
      i_reset_n = 1'b1;
      @(negedge i_clk);

      // Single swaps from idle
      for (int i = 0; i < 6; i++) begin
         clear_log();
         ack_delay = vecs[i].delay;
         acks0 = ext_acks + io_acks;
         i_io_chan = vecs[i].chan;
         i_io_addr = vecs[i].ioaddr;
         i_ext_code = vecs[i].code;
         if (vecs[i].cls <= 3) pulse_req(vecs[i].cls, vecs[i].code);
         if (vecs[i].cls == 4) i_ext_req = 1'b1;
         if (vecs[i].cls == 5) i_io_req = 1'b1;
         take(vecs[i].psw, vecs[i].ilc);
         chk($sformatf("v%0d_class", i), {61'd0, o_int_class}, 64'(vecs[i].cls));
         chk($sformatf("v%0d_busy", i), {63'd0, o_busy}, 64'd1);
         wait_load(lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_beats", i), 64'(log_addr.size()), 64'd4);
         exp_a[0] = vecs[i].old_a;
         exp_a[1] = vecs[i].old_a + 24'd4;
         exp_a[2] = vecs[i].new_a;
         exp_a[3] = vecs[i].new_a + 24'd4;
         if (log_addr.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
               chk($sformatf("v%0d_addr%0d", i, j), {40'd0, log_addr[j]}, {40'd0, exp_a[j]});
               chk($sformatf("v%0d_we%0d", i, j), {63'd0, log_we[j]}, (j < 2) ? 64'd1 : 64'd0);
            end
            chk($sformatf("v%0d_word0", i), {32'd0, log_data[0]}, {32'd0, vecs[i].w0});
            chk($sformatf("v%0d_word1", i), {32'd0, log_data[1]}, {32'd0, vecs[i].w1});
         end
         chk($sformatf("v%0d_psw_new", i), o_psw_new,
             {32'hC0DE_0000 | {8'd0, vecs[i].new_a}, 32'hC0DE_0000 | {8'd0, vecs[i].new_a + 24'd4}});
         @(negedge i_clk);
         chk($sformatf("v%0d_idle_after", i), {63'd0, o_busy}, 64'd0);
         chk($sformatf("v%0d_acks", i), 64'(ext_acks + io_acks - acks0), (vecs[i].cls >= 4) ? 64'd1 : 64'd0);
      end

      // io masked off by PSW bit 3, then enabled
      clear_log();
      ack_delay = 0;
      i_io_chan = 3'd3;
      i_io_addr = 16'h0ABC;
      i_io_req = 1'b1;
      take(64'h0, 2'd0);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("io_masked_busy%0d", j), {63'd0, o_busy}, 64'd0);
         @(negedge i_clk);
      end
      take(64'h1000_0000_0000_0000, 2'd0);
      chk("io_enabled_class", {61'd0, o_int_class}, 64'd5);
      wait_load(lat);
      if (log_data.size() >= 1) chk("io_enabled_word0", {32'd0, log_data[0]}, 64'h1000_0ABC);
      else chk("io_enabled_beats", 64'(log_data.size()), 64'd4);
      @(negedge i_clk);

      // Priority: mck, svc and ext together
      clear_log();
      acks0 = ext_acks;
      i_ext_code = 8'h55;
      i_ext_req = 1'b1;
      i_mck_req = 1'b1;
      i_svc_req = 1'b1;
      i_svc_code = 8'h2A;
      @(negedge i_clk);
      i_mck_req = 1'b0;
      i_svc_req = 1'b0;
      take(64'h0104_0000_0000_0000, 2'd0);
      chk("pri_first_mck", {61'd0, o_int_class}, 64'd1);
      wait_load(lat);
`ifdef X2050_INTSCHED_CHAIN_EN
      chk("pri_second_svc", {61'd0, o_int_class}, 64'd3);
      @(negedge i_clk);
`else
      chk("pri_idle_between", {63'd0, o_busy}, 64'd0);
      take(64'h0104_0000_0000_0000, 2'd0);
      chk("pri_second_svc", {61'd0, o_int_class}, 64'd3);
`endif
      wait_load(lat);
      @(negedge i_clk);
      take(64'h0104_0000_0000_0000, 2'd0);
      chk("pri_third_ext", {61'd0, o_int_class}, 64'd4);
      wait_load(lat);
      @(negedge i_clk);
      seq_a = '{24'd48, 24'd52, 24'd112, 24'd116, 24'd32, 24'd36,
                24'd96, 24'd100, 24'd24, 24'd28, 24'd88, 24'd92};
      chk("pri_beats", 64'(log_addr.size()), 64'd12);
      if (log_addr.size() == 12)
         for (int j = 0; j < 12; j++)
            chk($sformatf("pri_addr%0d", j), {40'd0, log_addr[j]}, {40'd0, seq_a[j]});
      chk("pri_ext_acks", 64'(ext_acks - acks0), 64'd1);

      // pgm pulse in the same cycle as its own grant stays pending
      clear_log();
      pulse_req(2, 8'h11);
      i_pgm_req = 1'b1;
      i_pgm_code = 8'h22;
      take(64'h0, 2'd1);
      i_pgm_req = 1'b0;
      wait_load(lat);
`ifdef X2050_INTSCHED_CHAIN_EN
      @(negedge i_clk);
`else
      @(negedge i_clk);
      take(64'h0, 2'd1);
`endif
      chk("retain_class", {61'd0, o_int_class}, 64'd2);
      wait_load(lat);
      @(negedge i_clk);
      chk("retain_beats", 64'(log_data.size()), 64'd8);
      if (log_data.size() == 8) begin
         chk("retain_code_first", {32'd0, log_data[0]}, 64'h0000_0011);
         tmp = log_data[4];
         chk("retain_code_second", {48'd0, tmp[15:0]}, 64'h0022);
      end

      // Reset during LD0 with svc queued behind pgm
      clear_log();
      ack_delay = 3;
      i_pgm_req = 1'b1;
      i_pgm_code = 8'h09;
      i_svc_req = 1'b1;
      i_svc_code = 8'h44;
      @(negedge i_clk);
      i_pgm_req = 1'b0;
      i_svc_req = 1'b0;
      take(64'h0, 2'd0);
      lat = 0;
      while (!(o_mem_req && !o_mem_we) && lat < 60) begin
         @(negedge i_clk);
         lat++;
      end
      chk("rst_mid_reached_ld0", {63'd0, o_mem_req && !o_mem_we}, 64'd1);
      @(posedge i_clk);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", {63'd0, o_mem_req}, 64'd0);
      chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_mid_class", {61'd0, o_int_class}, 64'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      loads0 = loads;
      take(64'h0, 2'd0);
      chk("rst_mid_pending_cleared", {63'd0, o_busy}, 64'd0);
      repeat (20) @(negedge i_clk);
      chk("rst_mid_no_load", 64'(loads - loads0), 64'd0);

      // New PSW enabling io: chained from DONE or held for the next boundary
      clear_log();
      ack_delay = 0;
      acks0 = io_acks;
      mem_words[26] = 32'h2000_0000;
      mem_words[27] = 32'h0000_0000;
      i_io_chan = 3'd2;
      i_io_addr = 16'h0777;
      i_io_req = 1'b1;
      pulse_req(2, 8'h07);
      take(64'h0, 2'd0);
      chk("chain_first_pgm", {61'd0, o_int_class}, 64'd2);
      wait_load(lat);
`ifdef X2050_INTSCHED_CHAIN_EN
      chk("chain_io_started", {61'd0, o_int_class}, 64'd5);
      @(negedge i_clk);
`else
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("chain_waits%0d", j), {63'd0, o_busy}, 64'd0);
         @(negedge i_clk);
      end
      take(64'h2000_0000_0000_0000, 2'd0);
      chk("chain_io_class", {61'd0, o_int_class}, 64'd5);
`endif
      wait_load(lat);
      @(negedge i_clk);
      chk("chain_beats", 64'(log_addr.size()), 64'd8);
      if (log_addr.size() == 8) begin
         chk("chain_io_addr", {40'd0, log_addr[4]}, 64'd56);
         chk("chain_io_word0", {32'd0, log_data[4]}, 64'h2000_0777);
      end
      chk("chain_io_acks", 64'(io_acks - acks0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
